// File: rtl/aec_gen2.sv
// aec_gen2: serial ASCII arithmetic expression evaluator.
// Characters are collected as single-digit hex operands and ( ) + - * tokens.
// On '=' the tokens are converted infix->postfix (shunting-yard), the operator
// stack is drained, the postfix queue is evaluated on a value stack, and the
// result (or an error) is presented for one cycle with valid.
// Handshake: a character is taken on a rising edge when ready=1 and busy=0;
// valid is a single-cycle pulse and qualifies err and result; busy covers the
// whole evaluation, from the cycle after '=' up to and including the valid cycle.
module aec_gen2 #(
    parameter int MAX_TOK = 16,
    parameter int RES_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [7:0]       ascii_in,
    output logic             busy,
    output logic             valid,
    output logic             err,
    output logic [RES_W-1:0] result,
    output logic [2:0]       state_dbg
);

    localparam int IW = $clog2(MAX_TOK);
    localparam int CW = $clog2(MAX_TOK + 1);

    // Token format: bit 4 = operator/paren flag, bits 3:0 = operand value or op code
    localparam logic [3:0] OP_LP  = 4'd0;
    localparam logic [3:0] OP_RP  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [4:0] TOK_LP = {1'b1, OP_LP};

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_CONVERT = 3'd1,
        S_DRAIN   = 3'd2,
        S_EVAL    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // One datapath action per cycle, chosen by the FSM
    typedef enum logic [3:0] {
        A_NONE, A_Q_TOK, A_PUSH, A_POP_Q, A_POP_DISC,
        A_E_PUSH, A_E_OP, A_FIN_OK, A_FIN_ERR
    } act_t;

    state_t state, state_n;
    act_t   act;

    logic [4:0]       tok_mem [MAX_TOK];
    logic [4:0]       stack   [MAX_TOK];
    logic [4:0]       q_mem   [MAX_TOK];
    logic [RES_W-1:0] estack  [MAX_TOK];

    logic [CW-1:0] tok_cnt, rd_idx, sp, q_cnt, e_idx, esp;
    logic [IW-1:0] sp_m1, esp_m1, esp_m2;
    logic          ill_flag, ovf_flag, err_r;
    logic [RES_W-1:0] result_r;

    logic          accept, c_legal, c_eq;
    logic [4:0]    c_tok, cur, top, qcur;
    logic          cur_prec, top_prec;
    logic [RES_W-1:0] e_a, e_b, e_res;

    assign accept    = ready && (state == S_COLLECT);
    assign sp_m1     = IW'(sp - CW'(1));
    assign esp_m1    = IW'(esp - CW'(1));
    assign esp_m2    = IW'(esp - CW'(2));
    assign cur       = tok_mem[rd_idx[IW-1:0]];
    assign top       = stack[sp_m1];
    assign qcur      = q_mem[e_idx[IW-1:0]];
    assign cur_prec  = (cur[3:0] == OP_MUL);
    assign top_prec  = (top[3:0] == OP_MUL);
    assign e_a       = estack[esp_m2];
    assign e_b       = estack[esp_m1];

    assign busy      = (state != S_COLLECT);
    assign valid     = (state == S_DONE);
    assign err       = err_r;
    assign result    = result_r;
    assign state_dbg = state;

    // Character decode into token form
    always_comb begin
        c_legal = 1'b1;
        c_eq    = 1'b0;
        c_tok   = '0;
        if (ascii_in >= 8'h30 && ascii_in <= 8'h39)      c_tok = {1'b0, 4'(ascii_in - 8'h30)};
        else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) c_tok = {1'b0, 4'(ascii_in - 8'h57)};
        else if (ascii_in == 8'h28)                      c_tok = {1'b1, OP_LP};
        else if (ascii_in == 8'h29)                      c_tok = {1'b1, OP_RP};
        else if (ascii_in == 8'h2B)                      c_tok = {1'b1, OP_ADD};
        else if (ascii_in == 8'h2D)                      c_tok = {1'b1, OP_SUB};
        else if (ascii_in == 8'h2A)                      c_tok = {1'b1, OP_MUL};
        else if (ascii_in == 8'h3D)                      c_eq  = 1'b1;
        else                                             c_legal = 1'b0;
    end

    // Binary operator applied to the two top value-stack entries
    always_comb begin
        case (qcur[3:0])
            OP_ADD:  e_res = e_a + e_b;
            OP_SUB:  e_res = e_a - e_b;
            default: e_res = e_a * e_b;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_COLLECT;
        else     state <= state_n;
    end

    // Next-state and per-cycle action selection
    always_comb begin
        state_n = state;
        act     = A_NONE;
        case (state)
            S_COLLECT: begin
                if (accept && c_eq) state_n = S_CONVERT;
            end
            S_CONVERT: begin
                if (ill_flag || ovf_flag) begin
                    act = A_FIN_ERR; state_n = S_DONE;
                end else if (rd_idx == tok_cnt) begin
                    state_n = S_DRAIN;
                end else if (!cur[4]) begin
                    act = A_Q_TOK;
                end else if (cur[3:0] == OP_LP) begin
                    act = A_PUSH;
                end else if (cur[3:0] == OP_RP) begin
                    if (sp == '0)          begin act = A_FIN_ERR; state_n = S_DONE; end
                    else if (top == TOK_LP) act = A_POP_DISC;
                    else                    act = A_POP_Q;
                end else begin
                    if (sp != '0 && top != TOK_LP && top_prec >= cur_prec) act = A_POP_Q;
                    else                                                    act = A_PUSH;
                end
            end
            S_DRAIN: begin
                if (sp == '0)           state_n = S_EVAL;
                else if (top == TOK_LP) begin act = A_FIN_ERR; state_n = S_DONE; end
                else                    act = A_POP_Q;
            end
            S_EVAL: begin
                state_n = S_DONE;
                if (e_idx == q_cnt)        act = (esp == CW'(1)) ? A_FIN_OK : A_FIN_ERR;
                else if (!qcur[4])         begin act = A_E_PUSH; state_n = S_EVAL; end
                else if (esp < CW'(2))     act = A_FIN_ERR;
                else                       begin act = A_E_OP; state_n = S_EVAL; end
            end
            S_DONE: state_n = S_COLLECT;
            default: state_n = S_COLLECT;
        endcase
    end

    // Token store, stacks, queue, indices and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt  <= '0;
            rd_idx   <= '0;
            sp       <= '0;
            q_cnt    <= '0;
            e_idx    <= '0;
            esp      <= '0;
            ill_flag <= 1'b0;
            ovf_flag <= 1'b0;
            err_r    <= 1'b0;
            result_r <= '0;
        end else begin
            if (accept && !c_eq) begin
                if (!c_legal)                      ill_flag <= 1'b1;
                else if (tok_cnt == CW'(MAX_TOK))  ovf_flag <= 1'b1;
                else begin
                    tok_mem[tok_cnt[IW-1:0]] <= c_tok;
                    tok_cnt <= tok_cnt + CW'(1);
                end
            end
            case (act)
                A_Q_TOK: begin
                    q_mem[q_cnt[IW-1:0]] <= cur;
                    q_cnt  <= q_cnt + CW'(1);
                    rd_idx <= rd_idx + CW'(1);
                end
                A_PUSH: begin
                    stack[sp[IW-1:0]] <= cur;
                    sp     <= sp + CW'(1);
                    rd_idx <= rd_idx + CW'(1);
                end
                A_POP_Q: begin
                    q_mem[q_cnt[IW-1:0]] <= top;
                    q_cnt <= q_cnt + CW'(1);
                    sp    <= sp - CW'(1);
                end
                A_POP_DISC: begin
                    sp     <= sp - CW'(1);
                    rd_idx <= rd_idx + CW'(1);
                end
                A_E_PUSH: begin
                    estack[esp[IW-1:0]] <= RES_W'(qcur[3:0]);
                    esp   <= esp + CW'(1);
                    e_idx <= e_idx + CW'(1);
                end
                A_E_OP: begin
                    estack[esp_m2] <= e_res;
                    esp   <= esp - CW'(1);
                    e_idx <= e_idx + CW'(1);
                end
                A_FIN_OK: begin
                    err_r    <= 1'b0;
                    result_r <= estack[0];
                end
                A_FIN_ERR: begin
                    err_r    <= 1'b1;
                    result_r <= '0;
                end
                default: ;
            endcase
            if (state == S_DONE) begin
                tok_cnt  <= '0;
                rd_idx   <= '0;
                sp       <= '0;
                q_cnt    <= '0;
                e_idx    <= '0;
                esp      <= '0;
                ill_flag <= 1'b0;
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aec_gen2.sv
// Testbench for aec_gen2: 8-bit and 16-bit result instances driven in lockstep,
// directed cases plus random expressions checked against a value-stack model.
module tb_aec_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  ascii_in = 8'h00;
    logic        busy8, valid8, err8, busy16, valid16, err16;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [2:0]  st8, st16;

    int n_tests = 0;
    int n_fail  = 0;

    // clock / reset
    always #5 clk = ~clk;

    aec_gen2 #(.MAX_TOK(16), .RES_W(8)) dut8 (
        .clk(clk), .rst(rst), .ready(ready), .ascii_in(ascii_in),
        .busy(busy8), .valid(valid8), .err(err8), .result(res8), .state_dbg(st8)
    );

    aec_gen2 #(.MAX_TOK(16), .RES_W(16)) dut16 (
        .clk(clk), .rst(rst), .ready(ready), .ascii_in(ascii_in),
        .busy(busy16), .valid(valid16), .err(err16), .result(res16), .state_dbg(st16)
    );

    // ---------------- reference model ----------------
    // Direct shunting-yard evaluation on 32-bit values, masked at the end.
    logic [31:0] m_vals[$];
    int          m_ops[$];

    function automatic int m_prec(input int op);
        return (op == 104) ? 1 : 0;
    endfunction

    function automatic bit m_apply();
        logic [31:0] a, b;
        int op;
        if (m_vals.size() < 2 || m_ops.size() == 0) return 1'b0;
        op = m_ops.pop_back();
        b  = m_vals.pop_back();
        a  = m_vals.pop_back();
        case (op)
            102:     m_vals.push_back(a + b);
            103:     m_vals.push_back(a - b);
            default: m_vals.push_back(a * b);
        endcase
        return 1'b1;
    endfunction

    // tokens: 0..15 operands, 100 '(', 101 ')', 102 '+', 103 '-', 104 '*'
    function automatic void model(input string s, input int w, output bit e,
                                  output logic [31:0] r, output int n);
        int toks[$];
        bit bad;
        int c, t;
        bit ill = 1'b0;
        bit ovf = 1'b0;
        m_vals.delete();
        m_ops.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 61) break;
            t = -1;
            if (c >= 48 && c <= 57)       t = c - 48;
            else if (c >= 97 && c <= 102) t = c - 87;
            else if (c == 40) t = 100;
            else if (c == 41) t = 101;
            else if (c == 43) t = 102;
            else if (c == 45) t = 103;
            else if (c == 42) t = 104;
            if (t < 0)                  ill = 1'b1;
            else if (toks.size() >= 16) ovf = 1'b1;
            else                        toks.push_back(t);
        end
        n = toks.size();
        bad = ill | ovf;
        foreach (toks[i]) begin
            if (!bad) begin
                t = toks[i];
                if (t < 16) m_vals.push_back(32'(t));
                else if (t == 100) m_ops.push_back(t);
                else if (t == 101) begin
                    while (!bad && m_ops.size() > 0 && m_ops[$] != 100)
                        if (!m_apply()) bad = 1'b1;
                    if (m_ops.size() == 0) bad = 1'b1;
                    else if (!bad) void'(m_ops.pop_back());
                end else begin
                    while (!bad && m_ops.size() > 0 && m_ops[$] != 100 && m_prec(m_ops[$]) >= m_prec(t))
                        if (!m_apply()) bad = 1'b1;
                    m_ops.push_back(t);
                end
            end
        end
        while (!bad && m_ops.size() > 0) begin
            if (m_ops[$] == 100) bad = 1'b1;
            else if (!m_apply()) bad = 1'b1;
        end
        if (!bad && m_vals.size() != 1) bad = 1'b1;
        e = bad;
        r = bad ? 32'h0 : (m_vals[0] & ((32'h1 << w) - 32'h1));
    endfunction

    // ---------------- driver ----------------
    bit          o_seen, o_busy_bad, o_sync_bad, o_after_bad;
    int          o_lat;
    logic        o_err8, o_err16;
    logic [7:0]  o_res8;
    logic [15:0] o_res16;

    task automatic run_expr(input string s, input bit toggle, input bit junk);
        string junk_chars = "5+(=#";
        o_seen = 0; o_busy_bad = 0; o_sync_bad = 0; o_after_bad = 0; o_lat = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (toggle && $urandom_range(0, 1) == 1) begin
                ready = 1'b0; ascii_in = 8'h23; @(posedge clk); #1;
            end
            ready = 1'b1; ascii_in = s[i]; @(posedge clk); #1;
        end
        ready = 1'b0; ascii_in = 8'h00;
        while (!o_seen && o_lat < 400) begin
            if (busy8 !== 1'b1 || busy16 !== 1'b1) o_busy_bad = 1;
            if (valid8 === 1'b1) begin
                o_seen = 1;
                o_err8 = err8; o_res8 = res8; o_err16 = err16; o_res16 = res16;
                if (valid16 !== 1'b1) o_sync_bad = 1;
            end else begin
                if (valid16 === 1'b1) o_sync_bad = 1;
                if (junk) begin
                    ready = 1'($urandom_range(0, 1));
                    ascii_in = junk_chars[$urandom_range(0, 4)];
                end
                @(posedge clk); #1;
                o_lat++;
            end
        end
        ready = 1'b0; ascii_in = 8'h00;
        if (o_seen) begin
            @(posedge clk); #1;
            if (valid8 !== 1'b0 || busy8 !== 1'b0 || valid16 !== 1'b0 || busy16 !== 1'b0) o_after_bad = 1;
        end
    endtask

    function automatic string gen_expr();
        string hexs = "0123456789abcdef";
        string ops  = "+-*";
        string alph = "0123456789abcdef()+-*";
        string s = "";
        int depth = 0, n = 0, target, mode;
        mode = $urandom_range(0, 5);
        if (mode <= 3) begin
            target = $urandom_range(1, 17);
            for (int k = 0; k < 40; k++) begin
                while (depth < 3 && n < target - 2 && $urandom_range(0, 3) == 0) begin
                    s = {s, "("}; depth++; n++;
                end
                s = $sformatf("%s%c", s, hexs[$urandom_range(0, 15)]); n++;
                while (depth > 0 && $urandom_range(0, 2) == 0) begin
                    s = {s, ")"}; depth--; n++;
                end
                if (n + depth >= target) break;
                s = $sformatf("%s%c", s, ops[$urandom_range(0, 2)]); n++;
            end
            while (depth > 0) begin s = {s, ")"}; depth--; end
        end else begin
            target = $urandom_range(0, 8);
            for (int k = 0; k < target; k++)
                s = $sformatf("%s%c", s, alph[$urandom_range(0, 20)]);
            if (mode == 5) s = {s, "g"};
        end
        return {s, "="};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; ascii_in = 8'h31;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (valid8 !== 1'b0 || valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b/%b want 0", valid8, valid16); end
        n_tests++; if (err8 !== 1'b0 || err16 !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %b/%b want 0", err8, err16); end
        n_tests++; if (busy8 !== 1'b0 || busy16 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b/%b want 0", busy8, busy16); end
        n_tests++; if (res8 !== 8'h0 || res16 !== 16'h0)    begin n_fail++; $display("FAIL reset_result got %h/%h want 0", res8, res16); end
        n_tests++; if (st8 !== 3'd0)                        begin n_fail++; $display("FAIL reset_state got %0d want 0", st8); end
        ready = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        string       cases [6] = '{"2+3*4=", "(2+3)*4=", "9-3-2=", "f-(a-1)=", "1-5=", "f*f*f="};
        logic [7:0]  exp8  [6] = '{8'd14, 8'd20, 8'd4, 8'd6, 8'hFC, 8'h2F};
        logic [15:0] exp16 [6] = '{16'd14, 16'd20, 16'd4, 16'd6, 16'hFFFC, 16'h0D2F};
        int          ntok  [6] = '{5, 7, 5, 7, 3, 5};
        for (int i = 0; i < 6; i++) begin
            run_expr(cases[i], 1'b0, 1'b0);
            n_tests++; if (!o_seen) begin n_fail++; $display("FAIL arith_timeout %s: no valid within 400 cycles", cases[i]); end
            else begin
                n_tests++; if (o_err8 !== 1'b0 || o_err16 !== 1'b0) begin n_fail++; $display("FAIL arith_err %s got %b/%b want 0", cases[i], o_err8, o_err16); end
                n_tests++; if (o_res8 !== exp8[i])   begin n_fail++; $display("FAIL arith_res8 %s got %h want %h", cases[i], o_res8, exp8[i]); end
                n_tests++; if (o_res16 !== exp16[i]) begin n_fail++; $display("FAIL arith_res16 %s got %h want %h", cases[i], o_res16, exp16[i]); end
                n_tests++; if (o_busy_bad || o_sync_bad || o_after_bad) begin n_fail++; $display("FAIL arith_handshake %s busy_bad=%0d sync_bad=%0d after_bad=%0d want 0", cases[i], o_busy_bad, o_sync_bad, o_after_bad); end
                n_tests++; if (o_lat > 3 * ntok[i] + 4) begin n_fail++; $display("FAIL arith_latency %s got %0d want <= %0d", cases[i], o_lat, 3 * ntok[i] + 4); end
            end
        end
    endtask

    task automatic test_errors();
        string cases [6] = '{"(1+2=", "1+2)=", "1+*2=", "=", "1#2=", "1+1+1+1+1+1+1+1+1="};
        int    ntok  [6] = '{4, 4, 4, 0, 2, 16};
        for (int i = 0; i < 6; i++) begin
            run_expr(cases[i], 1'b0, 1'b0);
            n_tests++; if (!o_seen) begin n_fail++; $display("FAIL err_timeout %s: no valid within 400 cycles", cases[i]); end
            else begin
                n_tests++; if (o_err8 !== 1'b1 || o_err16 !== 1'b1) begin n_fail++; $display("FAIL err_flag %s got %b/%b want 1", cases[i], o_err8, o_err16); end
                n_tests++; if (o_res8 !== 8'h0 || o_res16 !== 16'h0) begin n_fail++; $display("FAIL err_result %s got %h/%h want 0", cases[i], o_res8, o_res16); end
                n_tests++; if (o_lat > 3 * ntok[i] + 4 || o_after_bad) begin n_fail++; $display("FAIL err_timing %s lat %0d want <= %0d after_bad=%0d", cases[i], o_lat, 3 * ntok[i] + 4, o_after_bad); end
            end
        end
    endtask

    task automatic test_handshake();
        for (int k = 0; k < 4; k++) begin
            run_expr("3*4=", 1'b1, 1'b1);
            n_tests++;
            if (!o_seen || o_err8 !== 1'b0 || o_res8 !== 8'd12 || o_res16 !== 16'd12 || o_busy_bad)
                begin n_fail++; $display("FAIL handshake_3x4 seen=%0d err=%b res=%h/%h busy_bad=%0d want 1/0/0c/000c/0", o_seen, o_err8, o_res8, o_res16, o_busy_bad); end
        end
    endtask

    task automatic test_reset_mid_eval();
        string s = "1+2*3+4=";
        int    w = 0;
        bit    stray = 0;
        for (int i = 0; i < s.len(); i++) begin
            ready = 1'b1; ascii_in = s[i]; @(posedge clk); #1;
        end
        ready = 1'b0;
        while (st8 !== 3'd3 && w < 100) begin @(posedge clk); #1; w++; end
        n_tests++; if (st8 !== 3'd3) begin n_fail++; $display("FAIL rst_reach_eval state %0d want 3", st8); end
        rst = 1'b1; ready = 1'b1; ascii_in = 8'h35;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b0; ascii_in = 8'h00;
        n_tests++; if (valid8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 8'h0 || st8 !== 3'd0)
            begin n_fail++; $display("FAIL rst_mid_eval valid=%b busy=%b res=%h state=%0d want 0/0/00/0", valid8, busy8, res8, st8); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid8 === 1'b1 || valid16 === 1'b1) stray = 1;
        end
        n_tests++; if (stray) begin n_fail++; $display("FAIL rst_no_valid got a valid pulse want none"); end
        run_expr("1+1=", 1'b0, 1'b0);
        n_tests++; if (!o_seen || o_err8 !== 1'b0 || o_res8 !== 8'd2)
            begin n_fail++; $display("FAIL rst_then_1p1 seen=%0d err=%b res=%h want 1/0/02", o_seen, o_err8, o_res8); end
    endtask

    task automatic test_random();
        string       s;
        bit          e8, e16;
        logic [31:0] r8, r16;
        int          n;
        for (int k = 0; k < 150; k++) begin
            s = gen_expr();
            model(s, 8, e8, r8, n);
            model(s, 16, e16, r16, n);
            run_expr(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_tests++;
            if (!o_seen || o_err8 !== e8 || o_res8 !== r8[7:0] || o_err16 !== e16 || o_res16 !== r16[15:0] ||
                o_busy_bad || o_sync_bad || o_after_bad || o_lat > 3 * n + 4)
                begin n_fail++; $display("FAIL random %s seen=%0d err=%b/%b res=%h/%h lat=%0d flags=%0d%0d%0d want err=%b/%b res=%h/%h lat<=%0d",
                    s, o_seen, o_err8, o_err16, o_res8, o_res16, o_lat, o_busy_bad, o_sync_bad, o_after_bad, e8, e16, r8[7:0], r16[15:0], 3 * n + 4); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_errors();
        test_handshake();
        test_reset_mid_eval();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
